frame_encoder: RTL and testbench

FRAME_ENCODER -- requirements
Module: frame_encoder

---
 rtl/frame_encoder_if.sv | 25 ++
 rtl/frame_encoder.sv | 165 ++++++++++++++++
 tb/tb_frame_encoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/frame_encoder_if.sv
// Byte-side handshake and bit-side encoder signals for frame_encoder.
// The slave modport is the encoder; the master modport is the byte source plus bit_encoder.
interface frame_encoder_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic [2:0] in_bits;
  logic       in_last;
  logic       in_ready;
  logic       out_en;
  logic       out_data;
  logic       out_data_valid;
  logic       out_req;
  logic       last_tick;
  logic       underflow;

  modport master (
    output in_valid, in_data, in_bits, in_last, out_req, last_tick,
    input  in_ready, out_en, out_data, out_data_valid, underflow
  );

  modport slave (
    input  in_valid, in_data, in_bits, in_last, out_req, last_tick,
    output in_ready, out_en, out_data, out_data_valid, underflow
  );
endinterface

// File: rtl/frame_encoder.sv
// Serialises bytes into a frame: SOC, LSB-first data, odd parity per full byte, EOC.
// One shift register plus one holding register; bits advance on out_req from bit_encoder.
module frame_encoder (
  input  logic           clk,
  input  logic           rst_n,
  frame_encoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SOC, DATA, PARITY, WAIT_END} state_t;

  state_t     state, state_n;
  logic [7:0] shift_q, shift_n;
  logic [3:0] cnt_q, cnt_n;
  logic       par_q, par_n, last_q, last_n, part_q, part_n;
  logic [7:0] hold_data_q, hold_data_n;
  logic [2:0] hold_bits_q, hold_bits_n;
  logic       hold_last_q, hold_last_n, hold_full_q, hold_full_n;
  logic       od_q, od_n, odv_q, odv_n, en_q, en_n, uf_q, uf_n;

  logic       xfer;
  logic       ld_avail, ld_last, ld_part;
  logic [7:0] ld_data;
  logic [2:0] ld_bits;
  logic [3:0] ld_cnt;

  assign bus.in_ready       = rst_n && !hold_full_q && (state != WAIT_END);
  assign bus.out_en         = en_q;
  assign bus.out_data       = od_q;
  assign bus.out_data_valid = odv_q;
  assign bus.underflow      = uf_q;

  assign xfer = bus.in_valid && bus.in_ready;

  // Next byte for a shift-register load: the holding register if full, else a same-tick transfer
  assign ld_avail = hold_full_q || xfer;
  assign ld_data  = hold_full_q ? hold_data_q : bus.in_data;
  assign ld_bits  = hold_full_q ? hold_bits_q : bus.in_bits;
  assign ld_last  = hold_full_q ? hold_last_q : bus.in_last;
  assign ld_part  = ld_last && (ld_bits != 3'd0);
  assign ld_cnt   = ld_part ? {1'b0, ld_bits} : 4'd8;

  always_comb begin
    state_n     = state;
    shift_n     = shift_q;
    cnt_n       = cnt_q;
    par_n       = par_q;
    last_n      = last_q;
    part_n      = part_q;
    hold_data_n = hold_data_q;
    hold_bits_n = hold_bits_q;
    hold_last_n = hold_last_q;
    hold_full_n = hold_full_q;
    od_n        = od_q;
    odv_n       = odv_q;
    en_n        = en_q;
    uf_n        = 1'b0;

    if (xfer && state != IDLE) begin
      hold_data_n = bus.in_data;
      hold_bits_n = bus.in_bits;
      hold_last_n = bus.in_last;
      hold_full_n = 1'b1;
    end

    case (state)
      IDLE: begin
        if (ld_avail) begin
          shift_n     = ld_data;
          cnt_n       = ld_cnt;
          par_n       = ~^ld_data;
          last_n      = ld_last;
          part_n      = ld_part;
          hold_full_n = 1'b0;
          od_n        = 1'b1;
          odv_n       = 1'b1;
          state_n     = SOC;
        end
      end
      SOC: begin
        en_n = 1'b1;
        if (bus.out_req) begin
          od_n    = shift_q[0];
          state_n = DATA;
        end
      end
      DATA: begin
        if (bus.out_req) begin
          if (cnt_q == 4'd1) begin
            if (part_q) begin
              od_n    = 1'b0;
              odv_n   = 1'b0;
              state_n = WAIT_END;
            end else begin
              od_n    = par_q;
              state_n = PARITY;
            end
          end else begin
            shift_n = shift_q >> 1;
            od_n    = shift_q[1];
            cnt_n   = cnt_q - 4'd1;
          end
        end
      end
      PARITY: begin
        if (bus.out_req) begin
          if (!last_q && ld_avail) begin
            shift_n     = ld_data;
            cnt_n       = ld_cnt;
            par_n       = ~^ld_data;
            last_n      = ld_last;
            part_n      = ld_part;
            hold_full_n = 1'b0;
            od_n        = ld_data[0];
            state_n     = DATA;
          end else begin
            uf_n    = !last_q;
            od_n    = 1'b0;
            odv_n   = 1'b0;
            state_n = WAIT_END;
          end
        end
      end
      WAIT_END: begin
        if (bus.last_tick) begin
          en_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      last_q      <= 1'b0;
      part_q      <= 1'b0;
      hold_data_q <= '0;
      hold_bits_q <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      od_q        <= 1'b0;
      odv_q       <= 1'b0;
      en_q        <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      state       <= state_n;
      shift_q     <= shift_n;
      cnt_q       <= cnt_n;
      par_q       <= par_n;
      last_q      <= last_n;
      part_q      <= part_n;
      hold_data_q <= hold_data_n;
      hold_bits_q <= hold_bits_n;
      hold_last_q <= hold_last_n;
      hold_full_q <= hold_full_n;
      od_q        <= od_n;
      odv_q       <= odv_n;
      en_q        <= en_n;
      uf_q        <= uf_n;
    end
  end
endmodule

// File: tb/tb_frame_encoder.sv
// Directed bench for frame_encoder: models bit_encoder timing (128-tick bit period)
// and scoreboards every consumed bit and every out_en high duration.
module tb_frame_encoder;
  logic clk = 1'b0;
  logic rst_n;
  frame_encoder_if bus ();

  frame_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic        exp_q[$];
  int unsigned dur_q[$];
  int unsigned frame_bits = 0;
  int unsigned bits_seen  = 0;
  int unsigned uf_cnt     = 0;
  int unsigned en_cnt     = 0;
  logic        mon_on     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic [2:0] b, input logic l, input logic first);
    int unsigned n;
    if (first) begin
      exp_q.push_back(1'b1);
      frame_bits = 1;
    end
    n = (l && b != 3'd0) ? int'(b) : 8;
    for (int i = 0; i < n; i++) exp_q.push_back(d[i]);
    frame_bits += n;
    if (n == 8) begin
      exp_q.push_back(($countones(d) % 2 == 0) ? 1'b1 : 1'b0);
      frame_bits += 1;
    end
    if (l) dur_q.push_back(frame_bits * 128);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [2:0] b, input logic l, input logic first);
    int unsigned t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_bits  = b;
    bus.in_last  = l;
    while (!bus.in_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", bus.in_ready, 1'b1);
    push_byte(d, b, l, first);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_frame_end(input string tag);
    int unsigned t = 0;
    while (!bus.out_en && t < 50) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (bus.out_en && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_en_low"}, bus.out_en, 1'b0);
    repeat (2) @(negedge clk);
    chk({tag, "_bits_left"}, exp_q.size(), 0);
    chk({tag, "_dur_left"}, dur_q.size(), 0);
  endtask

  // bit_encoder model plus output monitor
  initial begin
    int unsigned ph = 0;
    logic prev_en = 1'b0, prev_odv = 1'b0, prev_req = 1'b0;
    bus.out_req   = 1'b0;
    bus.last_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (bus.out_en && !bus.out_data_valid) chk("ready_in_wait_end", bus.in_ready, 1'b0);
        if (bus.out_data_valid !== prev_odv)
          chk("odv_change_cause", prev_req || (bus.out_data_valid && !prev_en), 1'b1);
        if (bus.underflow) uf_cnt++;
      end
      if (bus.out_en) en_cnt++;
      if (prev_en && !bus.out_en) begin
        if (mon_on) begin
          if (dur_q.size() == 0) chk("dur_unexpected", 0, 1);
          else chk("out_en_duration", en_cnt, dur_q.pop_front());
        end
        en_cnt = 0;
      end
      prev_en  = bus.out_en;
      prev_odv = bus.out_data_valid;
      if (bus.out_en) begin
        bus.out_req   = (ph == 63);
        bus.last_tick = (ph == 127);
        if (bus.out_req && bus.out_data_valid && mon_on) begin
          bits_seen++;
          if (exp_q.size() == 0) chk("bit_unexpected", 0, 1);
          else chk("bit", bus.out_data, exp_q.pop_front());
        end
        ph = (ph + 1) % 128;
      end else begin
        ph            = 0;
        bus.out_req   = 1'b0;
        bus.last_tick = 1'b0;
      end
      prev_req = bus.out_req;
    end
  end

  initial begin
    int unsigned uf0, base, t;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_bits  = '0;
    bus.in_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_en", bus.out_en, 1'b0);
    chk("rst_out_data", bus.out_data, 1'b0);
    chk("rst_odv", bus.out_data_valid, 1'b0);
    chk("rst_underflow", bus.underflow, 1'b0);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1'b1);

    // partial last byte, no parity, and frame-start timing
    send_byte(8'h26, 3'd7, 1'b1, 1'b1);
    chk("soc_out_data", bus.out_data, 1'b1);
    chk("soc_odv", bus.out_data_valid, 1'b1);
    chk("soc_out_en_late", bus.out_en, 1'b0);
    @(negedge clk);
    chk("soc_out_en_rise", bus.out_en, 1'b1);
    wait_frame_end("f26");

    send_byte(8'h00, 3'd0, 1'b1, 1'b1);
    wait_frame_end("f00");

    // back-to-back bytes via the holding register
    send_byte(8'h93, 3'd0, 1'b0, 1'b1);
    send_byte(8'h20, 3'd0, 1'b1, 1'b0);
    wait_frame_end("f93_20");

    // second byte withheld: underflow aborts after parity
    uf0 = uf_cnt;
    send_byte(8'h93, 3'd0, 1'b0, 1'b1);
    dur_q.push_back(frame_bits * 128);
    wait_frame_end("funder");
    chk("underflow_pulses", uf_cnt - uf0, 1);

    // reset in the 5th bit with a byte waiting in the holding register
    base = bits_seen;
    send_byte(8'h55, 3'd0, 1'b0, 1'b1);
    send_byte(8'hAA, 3'd0, 1'b1, 1'b0);
    t = 0;
    while (bits_seen < base + 4 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_bit5", bits_seen - base, 4);
    repeat (10) @(negedge clk);
    mon_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_en", bus.out_en, 1'b0);
    chk("abort_out_data", bus.out_data, 1'b0);
    chk("abort_odv", bus.out_data_valid, 1'b0);
    chk("abort_underflow", bus.underflow, 1'b0);
    chk("abort_in_ready", bus.in_ready, 1'b0);
    exp_q.delete();
    dur_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    mon_on = 1'b1;
    send_byte(8'h00, 3'd0, 1'b1, 1'b1);
    wait_frame_end("fpost");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
